// File: rtl/data_sram_responder_pkg.sv
// Shared widths, FSM encodings and request payload for the data-SRAM responder.
package data_sram_responder_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WEN_W  = 4;
    localparam int unsigned CNT_W  = 4;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    typedef struct packed {
        logic [WEN_W-1:0]  wen;
        logic [31:0]       addr;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/data_sram_responder_bytebank.sv
// Word-organised RAM with per-byte write enables and a registered read port.
module data_sram_responder_bytebank
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WEN_W-1:0]  we_i,
    input  logic              rd_en_i,
    input  logic              clr_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(WEN_W); b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    // Read word register: cleared on a miss, otherwise holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_responder.sv
// CPU data-SRAM responder: window decode, optional wait states, masked writes, word reads.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_en,
    input  logic [WEN_W-1:0]  req_wen,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);

    localparam logic [32:0] WIN_BYTES = 33'(1) << (ADDR_W + 2);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sram_req_t        lat_q, lat_d;
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;

    sram_req_t        acc_c;
    logic             acc_en_c;
    logic [31:0]      off_c;
    logic             hit_c;
    logic [WEN_W-1:0] bank_we_c;
    logic             bank_rd_c;
    logic             bank_clr_c;

    // Next state, request latch and selection of the request serviced this edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        acc_en_c = 1'b0;
        acc_c    = lat_q;
        case (state_q)
            S_IDLE: begin
                if (req_en) begin
                    if (WAIT_CYCLES == 0) begin
                        acc_en_c = 1'b1;
                        acc_c    = '{wen: req_wen, addr: req_addr, wdata: req_wdata};
                    end else begin
                        lat_d   = '{wen: req_wen, addr: req_addr, wdata: req_wdata};
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    acc_en_c = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Window decode; the offset wraps below BASE_ADDR so those addresses miss too.
    always_comb begin
        off_c      = acc_c.addr - BASE_ADDR;
        hit_c      = ({1'b0, off_c} < WIN_BYTES);
        bank_we_c  = (acc_en_c && hit_c && !rst) ? acc_c.wen : '0;
        bank_rd_c  = acc_en_c && hit_c && (acc_c.wen == '0);
        bank_clr_c = acc_en_c && !hit_c;
        rvalid_d   = acc_en_c;
        err_d      = acc_en_c && !hit_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        lat_q <= lat_d;
    end

    data_sram_responder_bytebank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (bank_we_c),
        .rd_en_i (bank_rd_c),
        .clr_i   (bank_clr_c),
        .idx_i   (off_c[ADDR_W+1:2]),
        .wdata_i (acc_c.wdata),
        .rdata_o (rdata)
    );

    assign rvalid = rvalid_q;
    assign err    = err_q;
    assign busy   = (state_q == S_WAIT);

endmodule
